decode_writeback: RTL and testbench
===================================

DECODE_WRITEBACK -- requirements
Module: decode_writeback

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have the port icode, input, 4 bits: instruction code of the current instruction (Y86 encoding, 0x0 halt .. 0xB popq).
REQ-004 The block SHALL have the port rA, input, 4 bits: first register specifier; 0xF means none.
REQ-005 The block SHALL have the port rB, input, 4 bits: second register specifier; 0xF means none.
REQ-006 The block SHALL have the port cnd, input, 1 bit: condition result from execute, which gates the cmovXX write.
REQ-007 The block SHALL have the port valE, input, 64 bits: execute result to be written back.
REQ-008 The block SHALL have the port valM, input, 64 bits: memory read data to be written back.
REQ-009 The block SHALL have the port wb_en, input, 1 bit: writeback enable; writeback is suppressed while it is 0.
REQ-010 The block SHALL have the port dbg_rid, input, 4 bits: debug read register id.
REQ-011 The block SHALL have the port valA, output, 64 bits: operand A to execute.
REQ-012 The block SHALL have the port valB, output, 64 bits: operand B to execute.
REQ-013 The block SHALL have the port dbg_val, output, 64 bits: contents of register dbg_rid; 0 when dbg_rid = 0xF.

Function
REQ-014 The block SHALL hold a register file of 15 x 64-bit registers, ids 0x0..0xE, with rsp = 0x4; id 0xF SHALL denote no register and have no storage.
REQ-015 srcA SHALL be rA for icode 2, 4, 6, 0xA; 0x4 for icode 9, 0xB; 0xF otherwise.
REQ-016 srcB SHALL be rB for icode 4, 5, 6; 0x4 for icode 8, 9, 0xA, 0xB; 0xF otherwise.
REQ-017 dstE SHALL be rB for icode 3 and 6, and for icode 2 only when cnd = 1; 0x4 for icode 8, 9, 0xA, 0xB; 0xF otherwise (including cmovXX with cnd = 0).
REQ-018 dstM SHALL be rA for icode 5 and 0xB; 0xF otherwise.
REQ-019 valA and valB SHALL be combinational reads of reg[srcA] and reg[srcB], with zero latency; a source of 0xF SHALL read as 64'h0.
REQ-020 Reads SHALL return pre-edge contents: a write at edge N SHALL become visible on valA, valB and dbg_val only after edge N.
REQ-021 On a rising edge with wb_en = 1 and rst = 0, the block SHALL write reg[dstE] <= valE if dstE != 0xF, and reg[dstM] <= valM if dstM != 0xF.
REQ-022 When dstE = dstM != 0xF (popq %rsp), valM SHALL win and valE SHALL be discarded.
REQ-023 Invalid icode values (0xC..0xF) SHALL produce srcA = srcB = dstE = dstM = 0xF, so that no write occurs and both reads are 0.
REQ-024 With wb_en = 0, the register file SHALL hold its contents; reads SHALL remain active.

Reset
REQ-025 When rst = 1 at a rising edge, all 15 registers SHALL become 64'h0, overriding any concurrent writeback.
REQ-026 Following reset, valA, valB and dbg_val SHALL read 0 for every id until a write occurs.
REQ-027 A reset asserted mid-program SHALL discard any writeback pending in that cycle, and no partial writes SHALL survive.

Verification
REQ-028 The bench SHALL check that, after reset, irmovq with icode = 3, rB = 2, valE = 0x1234 and wb_en = 1 leads, after the edge, to dbg_rid = 2 reading 0x1234, and that OPq with rA = 2, rB = 2 then gives valA = valB = 0x1234.
REQ-029 The bench SHALL check that cmovXX with icode = 2, rA = 1, rB = 3, valE = 0x55 writes reg3 = 0x55 when cnd = 1, and leaves reg3 unchanged at 0 when cnd = 0.
REQ-030 The bench SHALL check that popq %rsp, with icode = 0xB, rA = 4, valE = 0x108 and valM = 0xABC, leaves reg4 = 0xABC after the edge, and that before that edge valA = valB = old reg4.
REQ-031 The bench SHALL check that pushq with icode = 0xA, rA = 0, reg0 = 0x7 and reg4 = 0x100 gives valA = 0x7 and valB = 0x100, and that valE = 0xF8 updates reg4 to 0xF8.
REQ-032 The bench SHALL check that wb_en = 0 with icode = 3, rB = 5 and valE = 0x99 leaves reg5 unchanged, and that icode = 0xD gives valA = valB = 0 with no write.
REQ-033 The bench SHALL check that asserting rst in the same cycle as an irmovq to reg6 leaves all registers at 0, including reg6.

Source files
------------

// File: rtl/decode_writeback.sv
// Y86 decode/writeback stage: derives source and destination register ids from
// icode, serves two combinational operand reads plus a debug port, and writes back valE/valM.
module decode_writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_en,
    input  logic [3:0]  dbg_rid,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] dbg_val
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Id 0xF is "no register" and has no storage behind it.
    logic [63:0] regFile [15];

    logic [3:0] srcA;
    logic [3:0] srcB;
    logic [3:0] dstE;
    logic [3:0] dstM;

    // Register id selection per instruction; cmovXX drops its write when cnd is false.
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            I_RRMOVQ: begin
                srcA = rA;
                dstE = cnd ? rB : RNONE;
            end
            I_IRMOVQ: begin
                dstE = rB;
            end
            I_RMMOVQ: begin
                srcA = rA;
                srcB = rB;
            end
            I_MRMOVQ: begin
                srcB = rB;
                dstM = rA;
            end
            I_OPQ: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            I_CALL: begin
                srcB = RSP;
                dstE = RSP;
            end
            I_RET: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
            end
            I_PUSHQ: begin
                srcA = rA;
                srcB = RSP;
                dstE = RSP;
            end
            I_POPQ: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
                dstM = rA;
            end
            default: begin
                srcA = RNONE;
            end
        endcase
    end

    assign valA    = (srcA    == RNONE) ? 64'h0 : regFile[srcA];
    assign valB    = (srcB    == RNONE) ? 64'h0 : regFile[srcB];
    assign dbg_val = (dbg_rid == RNONE) ? 64'h0 : regFile[dbg_rid];

    // Writeback: the M port is checked first so popq %rsp keeps the loaded value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regFile[i] <= 64'h0;
            end
        end else if (wb_en) begin
            for (int i = 0; i < 15; i++) begin
                if (dstM == 4'(i)) begin
                    regFile[i] <= valM;
                end else if (dstE == 4'(i)) begin
                    regFile[i] <= valE;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: directed Y86 scenarios plus random
// instruction streams compared against an architectural register-file model.
module tb_decode_writeback;

    logic        clk;
    logic        rst;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        wb_en;
    logic [3:0]  dbg_rid;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] dbg_val;

    int checks;
    int errors;

    logic [63:0] model [15];

    decode_writeback dut (
        .clk     (clk),
        .rst     (rst),
        .icode   (icode),
        .rA      (rA),
        .rB      (rB),
        .cnd     (cnd),
        .valE    (valE),
        .valM    (valM),
        .wb_en   (wb_en),
        .dbg_rid (dbg_rid),
        .valA    (valA),
        .valB    (valB),
        .dbg_val (dbg_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural rules for which registers an instruction reads and writes.
    function automatic logic [3:0] refSrcA(input logic [3:0] ic, input logic [3:0] a);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return a;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] refSrcB(input logic [3:0] ic, input logic [3:0] b);
        if (ic inside {4'h4, 4'h5, 4'h6}) return b;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] refDstE(input logic [3:0] ic, input logic [3:0] b, input logic c);
        if (ic == 4'h3 || ic == 4'h6 || (ic == 4'h2 && c)) return b;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] refDstM(input logic [3:0] ic, input logic [3:0] a);
        if (ic == 4'h5 || ic == 4'hB) return a;
        return 4'hF;
    endfunction

    function automatic logic [63:0] refRead(input logic [3:0] id);
        if (id == 4'hF) return 64'h0;
        return model[id];
    endfunction

    task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic [63:0] e, input logic [63:0] m,
                         input logic en);
        icode = ic;
        rA    = a;
        rB    = b;
        cnd   = c;
        valE  = e;
        valM  = m;
        wb_en = en;
        #1;
    endtask

    // One rising edge, with the model updated from the inputs held across it.
    task automatic tick();
        logic [3:0] e;
        logic [3:0] m;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 15; i++) model[i] = 64'h0;
        end else if (wb_en) begin
            e = refDstE(icode, rB, cnd);
            m = refDstM(icode, rA);
            if (e != 4'hF) model[e] = valE;
            if (m != 4'hF) model[m] = valM;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            dbg_rid = 4'(i);
            drive(4'h6, 4'(i), 4'(i), 1'b0, 64'h0, 64'h0, 1'b0);
            checks++;
            if (dbg_val !== 64'h0) begin
                errors++;
                $display("[TB] FAIL reset_dbg id=%0d got %h want 0", i, dbg_val);
            end
            checks++;
            if (valA !== 64'h0 || valB !== 64'h0) begin
                errors++;
                $display("[TB] FAIL reset_ops id=%0d got A=%h B=%h want 0", i, valA, valB);
            end
        end
    endtask

    task automatic test_irmovq_opq();
        drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 1'b1);
        tick();
        dbg_rid = 4'h2;
        drive(4'h6, 4'h2, 4'h2, 1'b0, 64'h0, 64'h0, 1'b0);
        checks++;
        if (dbg_val !== 64'h1234) begin
            errors++;
            $display("[TB] FAIL irmovq_reg2 got %h want %h", dbg_val, 64'h1234);
        end
        checks++;
        if (valA !== 64'h1234 || valB !== 64'h1234) begin
            errors++;
            $display("[TB] FAIL opq_read got A=%h B=%h want 1234", valA, valB);
        end
    endtask

    task automatic test_cmov();
        dbg_rid = 4'h3;
        drive(4'h2, 4'h1, 4'h3, 1'b0, 64'h55, 64'h0, 1'b1);
        tick();
        checks++;
        if (dbg_val !== 64'h0) begin
            errors++;
            $display("[TB] FAIL cmov_not_taken got %h want 0", dbg_val);
        end
        drive(4'h2, 4'h1, 4'h3, 1'b1, 64'h55, 64'h0, 1'b1);
        tick();
        checks++;
        if (dbg_val !== 64'h55) begin
            errors++;
            $display("[TB] FAIL cmov_taken got %h want 55", dbg_val);
        end
    endtask

    task automatic test_popq_rsp();
        drive(4'h3, 4'hF, 4'h4, 1'b0, 64'h200, 64'h0, 1'b1);
        tick();
        dbg_rid = 4'h4;
        drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hABC, 1'b1);
        checks++;
        if (valA !== 64'h200 || valB !== 64'h200) begin
            errors++;
            $display("[TB] FAIL popq_pre_edge got A=%h B=%h want 200", valA, valB);
        end
        tick();
        checks++;
        if (dbg_val !== 64'hABC) begin
            errors++;
            $display("[TB] FAIL popq_rsp_wins got %h want abc", dbg_val);
        end
    endtask

    task automatic test_pushq();
        drive(4'h3, 4'hF, 4'h0, 1'b0, 64'h7, 64'h0, 1'b1);
        tick();
        drive(4'h3, 4'hF, 4'h4, 1'b0, 64'h100, 64'h0, 1'b1);
        tick();
        drive(4'hA, 4'h0, 4'hF, 1'b0, 64'hF8, 64'h0, 1'b1);
        checks++;
        if (valA !== 64'h7 || valB !== 64'h100) begin
            errors++;
            $display("[TB] FAIL pushq_read got A=%h B=%h want 7/100", valA, valB);
        end
        tick();
        dbg_rid = 4'h4;
        #1;
        checks++;
        if (dbg_val !== 64'hF8) begin
            errors++;
            $display("[TB] FAIL pushq_rsp got %h want f8", dbg_val);
        end
        dbg_rid = 4'h0;
        #1;
        checks++;
        if (dbg_val !== 64'h7) begin
            errors++;
            $display("[TB] FAIL pushq_src_kept got %h want 7", dbg_val);
        end
    endtask

    task automatic test_hold_and_invalid();
        logic [63:0] before5;
        before5 = model[5];
        drive(4'h3, 4'hF, 4'h5, 1'b0, 64'h99, 64'h99, 1'b0);
        tick();
        dbg_rid = 4'h5;
        #1;
        checks++;
        if (dbg_val !== before5) begin
            errors++;
            $display("[TB] FAIL wb_en_hold got %h want %h", dbg_val, before5);
        end
        drive(4'hD, 4'h2, 4'h4, 1'b1, 64'h77, 64'h88, 1'b1);
        checks++;
        if (valA !== 64'h0 || valB !== 64'h0) begin
            errors++;
            $display("[TB] FAIL invalid_reads got A=%h B=%h want 0", valA, valB);
        end
        tick();
        for (int i = 0; i < 15; i++) begin
            dbg_rid = 4'(i);
            #1;
            checks++;
            if (dbg_val !== model[i]) begin
                errors++;
                $display("[TB] FAIL invalid_no_write id=%0d got %h want %h", i, dbg_val, model[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] expA;
        logic [63:0] expB;
        for (int n = 0; n < 300; n++) begin
            rst     = ($urandom_range(0, 39) == 0);
            dbg_rid = 4'($urandom_range(0, 15));
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom_range(0, 4) != 0));
            expA = refRead(refSrcA(icode, rA));
            expB = refRead(refSrcB(icode, rB));
            checks++;
            if (valA !== expA || valB !== expB) begin
                errors++;
                $display("[TB] FAIL rand_ops n=%0d ic=%h got A=%h B=%h want A=%h B=%h",
                         n, icode, valA, valB, expA, expB);
            end
            checks++;
            if (dbg_val !== refRead(dbg_rid)) begin
                errors++;
                $display("[TB] FAIL rand_dbg n=%0d id=%h got %h want %h",
                         n, dbg_rid, dbg_val, refRead(dbg_rid));
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_override();
        for (int i = 0; i < 15; i++) begin
            drive(4'h3, 4'hF, 4'(i), 1'b0, {$urandom, $urandom} | 64'h1, 64'h0, 1'b1);
            tick();
        end
        rst = 1'b1;
        drive(4'h3, 4'hF, 4'h6, 1'b0, 64'hDEAD, 64'h0, 1'b1);
        tick();
        rst = 1'b0;
        drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            dbg_rid = 4'(i);
            #1;
            checks++;
            if (dbg_val !== 64'h0) begin
                errors++;
                $display("[TB] FAIL reset_override id=%0d got %h want 0", i, dbg_val);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        dbg_rid = 4'hF;
        for (int i = 0; i < 15; i++) model[i] = 64'h0;
        drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_irmovq_opq();
        test_cmov();
        test_popq_rsp();
        test_pushq();
        test_hold_and_invalid();
        test_random();
        test_reset_override();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
